// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
//   Multi-cycle radix-2 restoring divider plus its sequencing FSM for
//   DIV/DIVU in the E stage. The hazard unit asserts div_start while a divide
//   sits in E and holds stallE until div_ready pulses. An exception flush
//   (div_annul) aborts the operation so an annulled divide never reaches M.
//
//   Optional build macro: DIV_EARLY_EXIT_EN
//     defined   : operands with |a| < |b| (nonzero divisor) finish the cycle
//                 after accept with quotient 0 and remainder = div_a.
//     undefined : every nonzero divisor takes the full DATA_W-step path.
//
// Parameters
//   DATA_W     operand width and iteration count (32 is the verified width)
//   ZERO_QUOT  quotient returned on divide-by-zero (remainder is 0)
//
// Ports
//   clk         pipeline clock
//   rst         synchronous, active-high reset
//   div_start   divide present in E
//   div_signed  1 = DIV (signed), 0 = DIVU
//   div_a       dividend (rs), sampled only on accept
//   div_b       divisor (rt), sampled only on accept
//   div_annul   flush; aborts any operation, highest priority
//   div_result  {remainder (HI), quotient (LO)}, held until the next finish
//   div_ready   one-cycle pulse when div_result is valid
// ---------------------------------------------------------------------------
module div_ctrl #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] ZERO_QUOT = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic [DATA_W-1:0]     div_a,
  input  logic [DATA_W-1:0]     div_b,
  input  logic                  div_annul,
  output logic [2*DATA_W-1:0]   div_result,
  output logic                  div_ready
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      counter_reg;
  logic [DATA_W-1:0]     rem_reg;
  logic [DATA_W-1:0]     quo_reg;
  logic [DATA_W-1:0]     divisor_reg;
  logic                  neg_quo_reg;
  logic                  neg_rem_reg;
  logic [2*DATA_W-1:0]   div_result_reg;
  logic                  div_ready_reg;

  logic [DATA_W-1:0]     a_mag;
  logic [DATA_W-1:0]     b_mag;
  logic [DATA_W:0]       rem_shift;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     rem_next;
  logic [DATA_W-1:0]     quo_next;
  logic [DATA_W-1:0]     rem_fix;
  logic [DATA_W-1:0]     quo_fix;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // its correct unsigned magnitude.
  always_comb begin
    a_mag = (div_signed && div_a[DATA_W-1]) ? -div_a : div_a;
    b_mag = (div_signed && div_b[DATA_W-1]) ? -div_b : div_b;
  end

  // One restoring step. The partial remainder is always below the divisor,
  // so shifting in one bit needs only a single extra bit of headroom; the
  // borrow out of the subtraction decides the quotient bit.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[DATA_W-1]};
    diff      = rem_shift - {1'b0, divisor_reg};
    quo_next  = {quo_reg[DATA_W-2:0], 1'b0};
    rem_next  = rem_shift[DATA_W-1:0];
    if (!diff[DATA_W]) begin
      rem_next    = diff[DATA_W-1:0];
      quo_next[0] = 1'b1;
    end
    // Sign fixup for the final step; wraps modulo 2^DATA_W.
    quo_fix = neg_quo_reg ? -quo_next : quo_next;
    rem_fix = neg_rem_reg ? -rem_next : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      counter_reg    <= '0;
      rem_reg        <= '0;
      quo_reg        <= '0;
      divisor_reg    <= '0;
      neg_quo_reg    <= 1'b0;
      neg_rem_reg    <= 1'b0;
      div_result_reg <= '0;
      div_ready_reg  <= 1'b0;
    end else if (div_annul) begin
      // Abort from any state; the last completed result stays visible.
      state_reg     <= ST_IDLE;
      counter_reg   <= '0;
      div_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          div_ready_reg <= 1'b0;
          if (div_start) begin
            neg_quo_reg <= div_signed & (div_a[DATA_W-1] ^ div_b[DATA_W-1]);
            neg_rem_reg <= div_signed & div_a[DATA_W-1];
            quo_reg     <= a_mag;
            rem_reg     <= '0;
            divisor_reg <= b_mag;
            counter_reg <= '0;
            if (div_b == '0) begin
              state_reg <= ST_BYZERO;
`ifdef DIV_EARLY_EXIT_EN
            end else if (a_mag < b_mag) begin
              // Quotient is 0 and the remainder is the dividend itself,
              // already carrying the dividend's sign.
              state_reg      <= ST_END;
              div_result_reg <= {div_a, {DATA_W{1'b0}}};
              div_ready_reg  <= 1'b1;
`endif
            end else begin
              state_reg <= ST_ON;
            end
          end
        end

        ST_BYZERO: begin
          div_result_reg <= {{DATA_W{1'b0}}, ZERO_QUOT};
          div_ready_reg  <= 1'b1;
          state_reg      <= ST_END;
        end

        ST_ON: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          if (counter_reg == LAST_STEP) begin
            div_result_reg <= {rem_fix, quo_fix};
            div_ready_reg  <= 1'b1;
            state_reg      <= ST_END;
          end else begin
            counter_reg <= counter_reg + CNT_W'(1);
          end
        end

        ST_END: begin
          // div_start is ignored here so the finishing divide is not
          // accepted a second time while the pipeline is still releasing it.
          div_ready_reg <= 1'b0;
          counter_reg   <= '0;
          state_reg     <= ST_IDLE;
        end

        default: begin
          div_ready_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign div_result = div_result_reg;
  assign div_ready  = div_ready_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
//   Self-checking bench for div_ctrl: a table of directed vectors, hand
//   sequences for annul / reset / back-to-back starts, and randomized
//   operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_div_ctrl;

  localparam logic [31:0] ZQ = 32'hDEAD_BEEF;
`ifdef DIV_EARLY_EXIT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif
  localparam int EL = EARLY ? 1 : 33;   // latency for |a| < |b|

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;

  int checks;
  int errors;
  logic [63:0] last_res;

  div_ctrl #(.DATA_W(32), .ZERO_QUOT(ZQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_annul  (div_annul),
    .div_result (div_result),
    .div_ready  (div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    int          lat;
    logic [63:0] res;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [63:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
    int sa, sb, q, r;
    if (b == 32'h0) return {32'h0, ZQ};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic sgn);
    logic [31:0] am, bm;
    am = (sgn && a[31]) ? 32'(-a) : a;
    bm = (sgn && b[31]) ? 32'(-b) : b;
    if (b == 32'h0) return 2;
    if (EARLY != 0 && am < bm) return 1;
    return 33;
  endfunction

  // Drive one operation starting in the current (IDLE) cycle T; report the
  // cycle offset of the first div_ready and the result, then confirm the
  // pulse lasts a single cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input int exp_lat, input logic [63:0] exp_res, input string name);
    int n;
    bit got;
    div_start  = 1'b1;
    div_a      = a;
    div_b      = b;
    div_signed = sgn;
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      tick();
      n++;
      if (n == 1) begin
        // Operands must only matter at accept.
        div_start  = 1'b0;
        div_a      = $urandom;
        div_b      = $urandom;
        div_signed = 1'($urandom);
      end
      if (div_ready) got = 1'b1;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " result"}, div_result, exp_res);
    tick();
    check({name, " pulse"}, {63'h0, div_ready}, 64'h0);
    last_res = exp_res;
    $display("op %-12s a=%h b=%h s=%0d -> result=%h ready@T+%0d", name, a, b, sgn,
             div_result, n);
  endtask

  task automatic watch_no_ready(input int cycles, input string name);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (div_ready) pulses++;
    end
    check({name, " no ready"}, 64'(pulses), 64'h0);
  endtask

  vec_t vecs[14];

  initial begin
    int n;
    int first_n;
    int second_n;
    logic [63:0] first_res;
    logic [63:0] second_res;
    logic [31:0] ra, rb;
    logic        rs;

    checks    = 0;
    errors    = 0;
    last_res  = 64'h0;
    rst       = 1'b1;
    div_start = 1'b0;
    div_signed = 1'b0;
    div_a     = 32'h0;
    div_b     = 32'h0;
    div_annul = 1'b0;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 33, 64'h00000002_0000000E};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 33, 64'hFFFFFFFF_FFFFFFFD};
    vecs[2]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 33, 64'h00000000_80000000};
    vecs[3]  = '{32'd5,         32'd0,         1'b0, 2,  {32'h0, ZQ}};
    vecs[4]  = '{32'd3,         32'd10,        1'b0, EL, 64'h00000003_00000000};
    vecs[5]  = '{32'd9,         32'd3,         1'b0, 33, 64'h00000000_00000003};
    vecs[6]  = '{32'd7,         32'hFFFFFFFE,  1'b1, 33, 64'h00000001_FFFFFFFD};
    vecs[7]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 33, 64'hFFFFFFFF_00000003};
    vecs[8]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 33, 64'h00000000_FFFFFFFF};
    vecs[9]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 33, 64'h00000000_00000001};
    vecs[10] = '{32'hFFFFFFFF,  32'd2,         1'b1, EL, 64'hFFFFFFFF_00000000};
    vecs[11] = '{32'hFFFFFFFD,  32'd10,        1'b1, EL, 64'hFFFFFFFD_00000000};
    vecs[12] = '{32'd0,         32'd5,         1'b0, EL, 64'h0};
    vecs[13] = '{32'hFFFFFFF9,  32'd0,         1'b1, 2,  {32'h0, ZQ}};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset ready", {63'h0, div_ready}, 64'h0);
    check("reset result", div_result, 64'h0);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].lat, vecs[i].res,
            $sformatf("vec%0d", i));
    end

    // Annul in ON at T+10: never completes, result unchanged, restart at T+12.
    div_start  = 1'b1;
    div_a      = 32'd1000;
    div_b      = 32'd3;
    div_signed = 1'b0;
    for (n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) div_start = 1'b0;
    end
    div_annul = 1'b1;
    tick();
    div_annul = 1'b0;
    check("annul ready", {63'h0, div_ready}, 64'h0);
    check("annul result kept", div_result, last_res);
    tick();
    do_op(32'd100, 32'd7, 1'b0, 33, 64'h00000002_0000000E, "after_annul");

    // Annul together with start in IDLE: not accepted.
    div_start = 1'b1;
    div_a     = 32'd8;
    div_b     = 32'd0;
    div_annul = 1'b1;
    tick();
    div_start = 1'b0;
    div_annul = 1'b0;
    watch_no_ready(40, "annul_idle");
    check("annul_idle result kept", div_result, last_res);

    // Annul during BYZERO.
    div_start = 1'b1;
    div_a     = 32'd8;
    div_b     = 32'd0;
    tick();
    div_start = 1'b0;
    div_annul = 1'b1;
    tick();
    div_annul = 1'b0;
    watch_no_ready(5, "annul_byzero");
    check("annul_byzero result kept", div_result, last_res);

    // Reset mid-operation clears everything.
    div_start = 1'b1;
    div_a     = 32'd77;
    div_b     = 32'd5;
    tick();
    div_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst ready", {63'h0, div_ready}, 64'h0);
    check("midrst result", div_result, 64'h0);
    watch_no_ready(40, "midrst");
    last_res = 64'h0;

    // div_start held through END, then a new DIVU 9/3 accepted at T+34.
    div_start  = 1'b1;
    div_a      = 32'd100;
    div_b      = 32'd7;
    div_signed = 1'b0;
    first_n    = 0;
    second_n   = 0;
    first_res  = 64'h0;
    second_res = 64'h0;
    for (n = 1; n <= 75 && second_n == 0; n++) begin
      tick();
      if (div_ready) begin
        if (first_n == 0) begin
          first_n   = n;
          first_res = div_result;
        end else begin
          second_n   = n;
          second_res = div_result;
        end
      end
      if (n == 33) begin
        div_a = 32'd9;
        div_b = 32'd3;
      end
      if (n == 35) div_start = 1'b0;
    end
    div_start = 1'b0;
    check("held first latency", 64'(first_n), 64'd33);
    check("held first result", first_res, 64'h00000002_0000000E);
    check("held second latency", 64'(second_n), 64'd67);
    check("held second result", second_res, 64'h00000000_00000003);
    $display("op held_start  first@T+%0d=%h second@T+%0d=%h", first_n, first_res,
             second_n, second_res);
    tick();
    tick();

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: begin
          ra = 32'($urandom_range(0, 50));
          rb = 32'($urandom_range(1, 100));
        end
        4: rb = {16'h0, rb[15:0]};
        default: ;
      endcase
      do_op(ra, rb, rs, model_lat(ra, rb, rs), model_res(ra, rb, rs),
            $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
